piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter: the inverse of the 8-bit serial-in/parallel-out shift register. Accepts one WIDTH-bit word over a valid/ready handshake. Emits it one bit per clk on data_out, MSB-first or LSB-first as selected by mov. Feeds serial links and the shift-register receiver for loopback testing.

Parameters:
- WIDTH, 8, word length in bits; must be at least 2.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- load_valid  in  1  data_in and mov are valid this cycle.
- load_ready  out  1  serializer can accept a word this cycle.
- data_in  in  WIDTH  parallel word to transmit.
- mov  in  1  direction, sampled at accept: 0 = MSB-first (shift left), 1 = LSB-first (shift right).
- data_out  out  1  serial bit.
- out_valid  out  1  data_out carries a valid bit.
- busy  out  1  high while a word is in flight.
- done  out  1  one-cycle pulse coincident with the last bit of a word.

Behaviour:
- Reset (reset=0, async): state=IDLE, shift register=0, counter=0, latched direction=0.
  - Outputs at reset: data_out=0, out_valid=0, busy=0, done=0, load_ready=1.
- States:
  - IDLE: load_ready=1, out_valid=0, data_out=0.
  - SHIFT: out_valid=1, busy=1.
- Accept = load_valid && load_ready, sampled at the clk edge.
  - Captures data_in and mov into internal registers.
  - Counter <= WIDTH-1; state -> SHIFT.
- Latency: first bit is on data_out the cycle after accept. The word occupies exactly WIDTH consecutive cycles.
- Each SHIFT cycle:
  - data_out = sreg[WIDTH-1] if latched mov=0; sreg[0] if mov=1.
  - At the edge: shift by one in the latched direction, zero-filled; counter decrements.
- Last bit (counter==0):
  - done=1 and load_ready=1.
  - With accept in the same cycle: reload, stay in SHIFT, counter <= WIDTH-1. Back-to-back words have no idle gap.
  - Without accept: -> IDLE.
- load_ready=0 during SHIFT except on the last-bit cycle. load_valid is ignored then and must be held by the source until accepted.
- data_in or mov changing mid-word does not affect the word in flight.
- Reset mid-word: aborts immediately. No done pulse; the partial word is lost.
- busy = (state==SHIFT).

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, one extra SHIFT cycle drives the even-parity bit (XOR of the captured word) on data_out with out_valid=1.
  - done and load_ready move to the parity cycle. Frame length is WIDTH+1 cycles.
- Undefined: no parity cycle; frame length is WIDTH cycles; no parity logic synthesized.

Decomposition:
- Package piso_pkg:
  - state enum {IDLE, SHIFT}.
  - direction constants DIR_MSB_FIRST=1'b0, DIR_LSB_FIRST=1'b1.
  - default WIDTH constant.
- Sub-module piso_bit_counter: loadable down-counter, CNT_W bits, with load/enable/last outputs. Instantiated once.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset values: hold reset=0 for 2 cycles, then release -> data_out=0, out_valid=0, busy=0, done=0, load_ready=1.
- MSB-first: accept data_in=8'hB2 with mov=0 -> data_out over the next 8 cycles = 1,0,1,1,0,0,1,0. done high only on cycle 8; out_valid low on cycle 9.
- LSB-first: accept 8'hB2 with mov=1 -> 0,1,0,0,1,1,0,1. Toggling mov mid-word changes nothing.
- Back-to-back: load_valid held with 8'hF0 then 8'h0F -> 16 contiguous valid bits 11110000 00001111. load_ready pulses only on the cycle-8 last bit; no idle gap.
- Stall and hold: load_valid=1 with 8'h55 presented during cycle 3 of an in-flight word -> not accepted until the last-bit cycle. The in-flight bits are unchanged.
- Reset mid-word: assert reset=0 at bit 4 of 8'hA5 -> all outputs return to reset values asynchronously, with no done pulse. With PISO_PARITY_EN defined, 8'hB2 yields a 9th bit of 0 and done on cycle 9.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the piso_serializer block.
//   state_e        : serializer FSM states (IDLE, SHIFT)
//   DIR_*          : direction encodings for the latched mov bit
//   DEFAULT_WIDTH  : default word length
package piso_pkg;

    localparam int   DEFAULT_WIDTH = 8;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking the bits remaining in a word.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset (count -> 0)
//   load     in   load load_val this cycle (has priority over en)
//   load_val in   value to load (CNT_W bits)
//   en       in   decrement by one
//   last     out  count is zero (current bit is the last data bit)
module piso_bit_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted over a
// load_valid/load_ready handshake and emitted one bit per clock on data_out,
// MSB-first (mov=0) or LSB-first (mov=1). The last bit of a word can overlap
// the accept of the next word, so back-to-back words have no idle gap.
//
// Optional feature macro: PISO_PARITY_EN
//   When defined, each word is followed by one extra cycle carrying its
//   even-parity bit; done/load_ready move to that cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   load_valid in   data_in/mov valid this cycle
//   load_ready out  a word can be accepted this cycle
//   data_in    in   parallel word (WIDTH bits)
//   mov        in   direction, sampled at accept (0 MSB-first, 1 LSB-first)
//   data_out   out  serial bit
//   out_valid  out  data_out carries a valid bit
//   busy       out  a word is in flight
//   done       out  pulse on the final cycle of a frame
module piso_serializer
    import piso_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mov,
    output logic             data_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             dir_q, dir_d;
    logic             cnt_load, cnt_en, cnt_last;
    logic             frame_end, accept;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
    logic             par_phase_q, par_phase_d;
`endif

    piso_bit_counter #(
        .CNT_W(CNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .load_val(CNT_W'(WIDTH - 1)),
        .en      (cnt_en),
        .last    (cnt_last)
    );

    always_comb begin
        // Final cycle of the frame: last data bit, or the parity bit when enabled.
`ifdef PISO_PARITY_EN
        frame_end = (state_q == SHIFT) && par_phase_q;
`else
        frame_end = (state_q == SHIFT) && cnt_last;
`endif
        load_ready = (state_q == IDLE) || frame_end;
        accept     = load_valid && load_ready;
        done       = frame_end;
        busy       = (state_q == SHIFT);
        out_valid  = (state_q == SHIFT);

        data_out = 1'b0;
        if (state_q == SHIFT) begin
            data_out = (dir_q == DIR_LSB_FIRST) ? sreg_q[0] : sreg_q[WIDTH-1];
        end
`ifdef PISO_PARITY_EN
        if ((state_q == SHIFT) && par_phase_q) begin
            data_out = par_q;
        end
`endif

        state_d  = state_q;
        sreg_d   = sreg_q;
        dir_d    = dir_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
`ifdef PISO_PARITY_EN
        par_d       = par_q;
        par_phase_d = par_phase_q;
`endif

        if (accept) begin
            sreg_d   = data_in;
            dir_d    = mov;
            state_d  = SHIFT;
            cnt_load = 1'b1;
`ifdef PISO_PARITY_EN
            par_d       = ^data_in;
            par_phase_d = 1'b0;
`endif
        end else if (state_q == SHIFT) begin
            sreg_d = (dir_q == DIR_LSB_FIRST) ? {1'b0, sreg_q[WIDTH-1:1]}
                                              : {sreg_q[WIDTH-2:0], 1'b0};
            // Hold at zero on the last bit so an idle counter reads zero.
            cnt_en = !cnt_last;
            if (frame_end) begin
                state_d = IDLE;
            end
`ifdef PISO_PARITY_EN
            if (frame_end) begin
                par_phase_d = 1'b0;
            end else if (cnt_last) begin
                par_phase_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            dir_q   <= dir_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q       <= 1'b0;
            par_phase_q <= 1'b0;
        end else begin
            par_q       <= par_d;
            par_phase_q <= par_phase_d;
        end
    end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking testbench for piso_serializer. A bit-queue reference model
// predicts the serial stream, handshake and status outputs per cycle.
// Honours PISO_PARITY_EN the same way the design does.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    typedef struct packed {
        logic [W-1:0] w;
        logic         d;
    } word_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] data_in;
    logic         mov;
    logic         data_out;
    logic         out_valid;
    logic         busy;
    logic         done;

    int total  = 0;
    int passed = 0;

    word_t pend[$];
    logic  exp_q[$];
    logic [63:0] obs_bit, obs_vld, obs_done, obs_rdy, obs_busy;
    logic [63:0] exp_bit, exp_vld, exp_done, exp_rdy;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .data_in   (data_in),
        .mov       (mov),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    // Bit k of the frame carrying word w in direction d.
    function automatic logic model_bit(input logic [W-1:0] w, input logic d, input int k);
        if (k >= W) return ^w;
        return d ? w[k] : w[W-1-k];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives pending words (held until accepted), random junk otherwise, and
    // records observed and predicted outputs; the first cycle lands in the MSBs.
    task automatic run(input int n);
        obs_bit = '0; obs_vld = '0; obs_done = '0; obs_rdy = '0; obs_busy = '0;
        exp_bit = '0; exp_vld = '0; exp_done = '0; exp_rdy = '0;
        for (int i = 0; i < n; i++) begin
            logic acc;
            if (pend.size() > 0) begin
                load_valid = 1'b1;
                data_in    = pend[0].w;
                mov        = pend[0].d;
            end else begin
                load_valid = 1'b0;
                data_in    = W'($urandom);
                mov        = 1'($urandom);
            end
            obs_bit  = {obs_bit[62:0], data_out};
            obs_vld  = {obs_vld[62:0], out_valid};
            obs_done = {obs_done[62:0], done};
            obs_rdy  = {obs_rdy[62:0], load_ready};
            obs_busy = {obs_busy[62:0], busy};
            exp_bit  = {exp_bit[62:0], (exp_q.size() > 0) ? exp_q[0] : 1'b0};
            exp_vld  = {exp_vld[62:0], exp_q.size() > 0};
            exp_done = {exp_done[62:0], exp_q.size() == 1};
            exp_rdy  = {exp_rdy[62:0], exp_q.size() <= 1};
            acc = load_valid && (exp_q.size() <= 1);
            tick();
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) begin
                for (int k = 0; k < FRAME; k++) exp_q.push_back(model_bit(pend[0].w, pend[0].d, k));
                void'(pend.pop_front());
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; load_valid = 1'b0; data_in = '0; mov = 1'b0;
        tick(); tick();
        total++;
        if ({data_out, out_valid, busy, done, load_ready} !== 5'b00001)
            $display("FAIL reset_held got %b want 00001", {data_out, out_valid, busy, done, load_ready});
        else passed++;
        reset = 1'b1;
        tick();
        total++;
        if ({data_out, out_valid, busy, done, load_ready} !== 5'b00001)
            $display("FAIL reset_released got %b want 00001", {data_out, out_valid, busy, done, load_ready});
        else passed++;
    endtask

    task automatic test_msb_first();
        pend.push_back(word_t'{w: 8'hB2, d: 1'b0});
        run(FRAME + 2);
        total++;
        if (obs_bit[FRAME -: 8] !== 8'hB2) $display("FAIL msb_bits got %h want b2", obs_bit[FRAME -: 8]);
        else passed++;
        total++;
        if (obs_done !== 64'd2) $display("FAIL msb_done got %h want 2", obs_done);
        else passed++;
        total++;
        if (obs_vld !== (((64'd1 << FRAME) - 1) << 1))
            $display("FAIL msb_valid got %h want %h", obs_vld, ((64'd1 << FRAME) - 1) << 1);
        else passed++;
`ifdef PISO_PARITY_EN
        total++;
        if (obs_bit[1] !== 1'b0) $display("FAIL msb_parity got %b want 0", obs_bit[1]);
        else passed++;
`endif
        total++;
        if (obs_bit !== exp_bit) $display("FAIL msb_model got %h want %h", obs_bit, exp_bit);
        else passed++;
    endtask

    task automatic test_lsb_first();
        pend.push_back(word_t'{w: 8'hB2, d: 1'b1});
        run(FRAME + 2);
        total++;
        if (obs_bit[FRAME -: 8] !== 8'h4D) $display("FAIL lsb_bits got %h want 4d", obs_bit[FRAME -: 8]);
        else passed++;
        total++;
        if (obs_done !== 64'd2) $display("FAIL lsb_done got %h want 2", obs_done);
        else passed++;
        total++;
        if (obs_bit !== exp_bit) $display("FAIL lsb_model got %h want %h", obs_bit, exp_bit);
        else passed++;
    endtask

    task automatic test_back_to_back();
        pend.push_back(word_t'{w: 8'hF0, d: 1'b0});
        pend.push_back(word_t'{w: 8'h0F, d: 1'b0});
        run(2 * FRAME + 2);
`ifndef PISO_PARITY_EN
        total++;
        if (obs_bit[2*FRAME -: 16] !== 16'hF00F) $display("FAIL b2b_bits got %h want f00f", obs_bit[2*FRAME -: 16]);
        else passed++;
`endif
        total++;
        if (obs_vld !== (((64'd1 << (2 * FRAME)) - 1) << 1))
            $display("FAIL b2b_valid got %h want %h", obs_vld, ((64'd1 << (2 * FRAME)) - 1) << 1);
        else passed++;
        total++;
        if (obs_rdy !== ((64'd1 << (2 * FRAME + 1)) | (64'd1 << (FRAME + 1)) | 64'd3))
            $display("FAIL b2b_ready got %h want %h", obs_rdy,
                     (64'd1 << (2 * FRAME + 1)) | (64'd1 << (FRAME + 1)) | 64'd3);
        else passed++;
        total++;
        if (obs_bit !== exp_bit) $display("FAIL b2b_model got %h want %h", obs_bit, exp_bit);
        else passed++;
    endtask

    task automatic test_stall();
        pend.push_back(word_t'{w: 8'hC3, d: 1'b0});
        run(3);
        pend.push_back(word_t'{w: 8'h55, d: 1'b0});
        run(2 * FRAME - 1);
        total++;
        if (obs_rdy !== ((64'd1 << (FRAME + 1)) | 64'd3))
            $display("FAIL stall_ready got %h want %h", obs_rdy, (64'd1 << (FRAME + 1)) | 64'd3);
        else passed++;
        total++;
        if (obs_bit !== exp_bit) $display("FAIL stall_bits got %h want %h", obs_bit, exp_bit);
        else passed++;
        total++;
        if (obs_done !== exp_done) $display("FAIL stall_done got %h want %h", obs_done, exp_done);
        else passed++;
    endtask

    task automatic test_reset_mid_word();
        pend.push_back(word_t'{w: 8'hA5, d: 1'b0});
        run(5);
        total++;
        if (obs_done !== 64'd0) $display("FAIL midreset_predone got %h want 0", obs_done);
        else passed++;
        #1 reset = 1'b0;
        #1;
        total++;
        if ({data_out, out_valid, busy, done, load_ready} !== 5'b00001)
            $display("FAIL midreset_async got %b want 00001", {data_out, out_valid, busy, done, load_ready});
        else passed++;
        exp_q.delete();
        pend.delete();
        tick();
        reset = 1'b1;
        run(FRAME + 1);
        total++;
        if ((obs_done | obs_vld) !== 64'd0) $display("FAIL midreset_after got %h want 0", obs_done | obs_vld);
        else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int nw;
            nw = int'($urandom_range(1, 3));
            for (int j = 0; j < nw; j++) pend.push_back(word_t'{w: W'($urandom), d: 1'($urandom)});
            run(nw * FRAME + 1 + int'($urandom_range(0, 3)));
            total++;
            if (obs_bit !== exp_bit) $display("FAIL rand_bits it%0d got %h want %h", it, obs_bit, exp_bit);
            else passed++;
            total++;
            if (obs_vld !== exp_vld) $display("FAIL rand_valid it%0d got %h want %h", it, obs_vld, exp_vld);
            else passed++;
            total++;
            if (obs_busy !== exp_vld) $display("FAIL rand_busy it%0d got %h want %h", it, obs_busy, exp_vld);
            else passed++;
            total++;
            if (obs_done !== exp_done) $display("FAIL rand_done it%0d got %h want %h", it, obs_done, exp_done);
            else passed++;
            total++;
            if (obs_rdy !== exp_rdy) $display("FAIL rand_ready it%0d got %h want %h", it, obs_rdy, exp_rdy);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
